fp_mac_stream: RTL and testbench

- Parametrised, streaming floating-point multiply-accumulate for the low-precision inference datapath.
- Accepts one operand pair per clock and multiplies them. Accumulates products over a framed vector delimited by in_last.
- Emits one result per vector with a valid strobe and saturation flag.
- Generalises the fixed 5-bit MAC: configurable exponent/mantissa widths, framing, output handshake, saturation reporting and a multiply-only mode.

---
 rtl/fp_mac_stream.sv | 187 ++++++++++++++++++
 tb/tb_fp_mac_stream.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/fp_mac_stream.sv
// Streaming low-precision floating-point multiply-accumulate with framed vectors.
// The fixed three-stage pipeline is operand register -> product register -> accumulate/emit.
module fp_mac_stream #(
   parameter int EXP_W = 2,
   parameter int MAN_W = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   input  logic                   in_last,
   input  logic                   mul_only,
   input  logic [EXP_W+MAN_W:0]   a,
   input  logic [EXP_W+MAN_W:0]   b,
   output logic                   out_valid,
   output logic [EXP_W+MAN_W:0]   out,
   output logic                   out_sat
);

   localparam int W    = 1 + EXP_W + MAN_W;
   localparam int BIAS = (1 << (EXP_W - 1)) - 1;
   localparam int EMAX = (1 << EXP_W) - 1;
   localparam int PW   = 2 * MAN_W + 2;
   localparam int XW   = EXP_W + 3;
   // Fixed-point span wide enough to hold any sum of two normals exactly.
   localparam int FX_W = MAN_W + (1 << EXP_W);
   localparam logic [W-2:0]     MAX_MAG = '1;
   localparam logic [EXP_W-1:0] E_ONE   = EXP_W'(1);

   // S1 operand stage
   logic [W-1:0] a_q, a_d, b_q, b_d;
   logic         v1_q, v1_d, l1_q, l1_d, m1_q, m1_d;
   // S2 product stage
   logic [W-1:0] p_q, p_d;
   logic         psat_q, psat_d, v2_q, v2_d, l2_q, l2_d, m2_q, m2_d;
   // S3 accumulate / output stage
   logic [W-1:0] acc_q, acc_d, out_q, out_d;
   logic         sticky_q, sticky_d, out_sat_q, out_sat_d, out_valid_q, out_valid_d;

   // Multiplier working signals
   logic [PW-1:0]    man_a_x, man_b_x, prod;
   logic [XW-1:0]    pexp;
   logic [MAN_W-1:0] pman;
   logic             p_sign;

   // Adder working signals
   logic [FX_W-1:0]  xa, xb, mag;
   logic [MAN_W-1:0] add_man;
   logic [W-1:0]     add_sum;
   logic             add_sat, rs, sat_n;
   int               lead, er;

   always_comb begin
      v1_d = in_valid;
      l1_d = in_valid & in_last;
      m1_d = in_valid & mul_only;
      a_d  = in_valid ? a : '0;
      b_d  = in_valid ? b : '0;
   end

   // Product: exact mantissa product, renormalise by at most one bit, truncate.
   always_comb begin
      man_a_x = {{(MAN_W + 1){1'b0}}, 1'b1, a_q[MAN_W-1:0]};
      man_b_x = {{(MAN_W + 1){1'b0}}, 1'b1, b_q[MAN_W-1:0]};
      prod    = man_a_x * man_b_x;
      p_sign  = a_q[W-1] ^ b_q[W-1];
      pexp    = XW'(a_q[W-2:MAN_W]) + XW'(b_q[W-2:MAN_W]) + XW'(prod[PW-1]) - XW'(BIAS);
      pman    = MAN_W'(prod >> (prod[PW-1] ? MAN_W + 1 : MAN_W));
      p_d     = '0;
      psat_d  = 1'b0;
      if (a_q[W-2:MAN_W] == '0 || b_q[W-2:MAN_W] == '0) begin
         p_d = '0;
      end else if (pexp[XW-1] || pexp == '0) begin
         p_d = '0;
      end else if (pexp[XW-2:0] > (XW-1)'(EMAX)) begin
         p_d    = {p_sign, MAX_MAG};
         psat_d = 1'b1;
      end else begin
         p_d = {p_sign, pexp[EXP_W-1:0], pman};
      end
      v2_d = v1_q;
      l2_d = l1_q;
      m2_d = m1_q;
   end

   // Sum: both operands mapped onto a common fixed-point grid, so the signed
   // add is exact and truncation is just dropping bits below the leading one.
   always_comb begin
      xa = '0;
      xb = '0;
      if (acc_q[W-2:MAN_W] != '0)
         xa = FX_W'({1'b1, acc_q[MAN_W-1:0]}) << (acc_q[W-2:MAN_W] - E_ONE);
      if (p_q[W-2:MAN_W] != '0)
         xb = FX_W'({1'b1, p_q[MAN_W-1:0]}) << (p_q[W-2:MAN_W] - E_ONE);
      if (acc_q[W-1] == p_q[W-1]) begin
         mag = xa + xb;
         rs  = acc_q[W-1];
      end else if (xa >= xb) begin
         mag = xa - xb;
         rs  = acc_q[W-1];
      end else begin
         mag = xb - xa;
         rs  = p_q[W-1];
      end
      lead = 0;
      for (int i = 0; i < FX_W; i++) begin
         if (mag[i]) lead = i;
      end
      er      = lead - MAN_W + 1;
      add_man = (lead >= MAN_W) ? MAN_W'(mag >> (lead - MAN_W)) : '0;
      add_sum = '0;
      add_sat = 1'b0;
      if (mag == '0 || lead < MAN_W) begin
         add_sum = '0;
      end else if (er > EMAX) begin
         add_sum = {rs, MAX_MAG};
         add_sat = 1'b1;
      end else begin
         add_sum = {rs, EXP_W'(er), add_man};
      end
   end

   always_comb begin
      out_valid_d = 1'b0;
      out_d       = out_q;
      out_sat_d   = out_sat_q;
      acc_d       = acc_q;
      sticky_d    = sticky_q;
      sat_n       = sticky_q | psat_q | add_sat;
      if (v2_q) begin
         if (m2_q) begin
            out_d       = p_q;
            out_sat_d   = psat_q;
            out_valid_d = 1'b1;
         end else if (l2_q) begin
            out_d       = add_sum;
            out_sat_d   = sat_n;
            out_valid_d = 1'b1;
            acc_d       = '0;
            sticky_d    = 1'b0;
         end else begin
            acc_d    = add_sum;
            sticky_d = sat_n;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_q         <= '0;
         b_q         <= '0;
         v1_q        <= 1'b0;
         l1_q        <= 1'b0;
         m1_q        <= 1'b0;
         p_q         <= '0;
         psat_q      <= 1'b0;
         v2_q        <= 1'b0;
         l2_q        <= 1'b0;
         m2_q        <= 1'b0;
         acc_q       <= '0;
         sticky_q    <= 1'b0;
         out_q       <= '0;
         out_sat_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         a_q         <= a_d;
         b_q         <= b_d;
         v1_q        <= v1_d;
         l1_q        <= l1_d;
         m1_q        <= m1_d;
         p_q         <= p_d;
         psat_q      <= psat_d;
         v2_q        <= v2_d;
         l2_q        <= l2_d;
         m2_q        <= m2_d;
         acc_q       <= acc_d;
         sticky_q    <= sticky_d;
         out_q       <= out_d;
         out_sat_q   <= out_sat_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out       = out_q;
   assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_fp_mac_stream.sv
// Directed bench for fp_mac_stream: driver pushes the hand-computed result and its
// due cycle into a scoreboard; a negedge monitor pops and compares on every out_valid.
module tb_fp_mac_stream;
   localparam int EXP_W = 2;
   localparam int MAN_W = 2;
   localparam int W     = 1 + EXP_W + MAN_W;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid, in_last, mul_only;
   logic [W-1:0] a, b;
   logic         out_valid;
   logic [W-1:0] out;
   logic         out_sat;

   fp_mac_stream #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .mul_only  (mul_only),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out       (out),
      .out_sat   (out_sat)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // scoreboard: {sat, out} plus the cycle it must appear in
   logic [W:0] exp_q[$];
   int         due_q[$];
   int         n_checks = 0;
   int         n_fail   = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   // driver tasks
   task automatic beat(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic last,
                       input logic mo, input logic [W-1:0] ev, input logic es);
      @(negedge clk);
      in_valid = 1'b1;
      a        = aa;
      b        = bb;
      in_last  = last;
      mul_only = mo;
      if (last || mo) begin
         exp_q.push_back({es, ev});
         due_q.push_back(cyc + 3);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0;
         in_last  = 1'b0;
         mul_only = 1'b0;
         a        = W'($urandom_range(0, 31));
         b        = W'($urandom_range(0, 31));
      end
   endtask

   // monitor
   always @(negedge clk) begin
      logic [W:0] e;
      int         d;
      if (out_valid !== 1'b0) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_out_valid: got out_valid=%b out=0x%0h, expected no output (cycle %0d)",
                     out_valid, out, cyc);
         end else begin
            e = exp_q.pop_front();
            d = due_q.pop_front();
            check("out", 32'(out), 32'(e[W-1:0]));
            check("out_sat", 32'(out_sat), 32'(e[W]));
            check("latency", 32'(cyc), 32'(d));
         end
      end
   end

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      mul_only = 1'b0;
      a        = '0;
      b        = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("idle_valid", 32'(out_valid), 32'd0);
         check("idle_out", 32'(out), 32'd0);
         check("idle_sat", 32'(out_sat), 32'd0);
      end

      // 1*2 + 1*2 = 4.0
      beat(5'h04, 5'h08, 1'b0, 1'b0, 5'h00, 1'b0);
      beat(5'h04, 5'h08, 1'b1, 1'b0, 5'h0C, 1'b0);
      // mul_only 1.5*1.5 = 2.25 -> 2.0
      beat(5'h06, 5'h06, 1'b0, 1'b1, 5'h08, 1'b0);
      // open vector with an interleaved mul_only beat: 1 + 1 = 2.0, product -1.5
      beat(5'h04, 5'h04, 1'b0, 1'b0, 5'h00, 1'b0);
      beat(5'h14, 5'h06, 1'b0, 1'b1, 5'h16, 1'b0);
      beat(5'h04, 5'h04, 1'b1, 1'b0, 5'h08, 1'b0);
      // 4 + 4 saturates, then sticky must be clear for the next vector
      beat(5'h08, 5'h08, 1'b0, 1'b0, 5'h00, 1'b0);
      beat(5'h08, 5'h08, 1'b1, 1'b0, 5'h0F, 1'b1);
      beat(5'h04, 5'h04, 1'b1, 1'b0, 5'h04, 1'b0);
      // 1.5 - 1.0 = 0.5 flushes; 1 - 1 = 0
      beat(5'h06, 5'h04, 1'b0, 1'b0, 5'h00, 1'b0);
      beat(5'h14, 5'h04, 1'b1, 1'b0, 5'h00, 1'b0);
      beat(5'h04, 5'h04, 1'b0, 1'b0, 5'h00, 1'b0);
      beat(5'h14, 5'h04, 1'b1, 1'b0, 5'h00, 1'b0);
      // bubble inside a vector: 1 + (gap) + 1 = 2.0
      beat(5'h04, 5'h04, 1'b0, 1'b0, 5'h00, 1'b0);
      idle(2);
      beat(5'h04, 5'h04, 1'b1, 1'b0, 5'h08, 1'b0);
      // product saturation alone (7*7) and as sticky through a later add: 7 - 1 = 6.0
      beat(5'h0F, 5'h0F, 1'b0, 1'b1, 5'h0F, 1'b1);
      beat(5'h0F, 5'h0F, 1'b0, 1'b0, 5'h00, 1'b0);
      beat(5'h14, 5'h04, 1'b1, 1'b0, 5'h0E, 1'b1);
      // truncating add 1.5 + 1.25 = 2.75 -> 2.5; negative sum -1 + -1 = -2.0
      beat(5'h06, 5'h04, 1'b0, 1'b0, 5'h00, 1'b0);
      beat(5'h05, 5'h04, 1'b1, 1'b0, 5'h09, 1'b0);
      beat(5'h14, 5'h04, 1'b0, 1'b0, 5'h00, 1'b0);
      beat(5'h14, 5'h04, 1'b1, 1'b0, 5'h18, 1'b0);
      idle(6);

      // reset one cycle after the first beat of a vector discards it
      beat(5'h04, 5'h04, 1'b0, 1'b0, 5'h00, 1'b0);
      @(negedge clk);
      reset    = 1'b1;
      in_valid = 1'b1;
      a        = 5'h04;
      b        = 5'h04;
      in_last  = 1'b0;
      mul_only = 1'b0;
      @(negedge clk);
      reset    = 1'b0;
      in_valid = 1'b0;
      check("reset_out", 32'(out), 32'd0);
      check("reset_sat", 32'(out_sat), 32'd0);
      beat(5'h04, 5'h04, 1'b1, 1'b0, 5'h04, 1'b0);
      idle(1);

      for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      idle(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
